// File: rtl/aclint_pkg.sv
// Shared constants, register selectors and decode helpers for the ACLINT machine timer block.
package aclint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;
    localparam logic [15:0] SETSSIP_BASE  = 16'hC000;

    localparam logic [63:0] MTIME_RST    = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam int unsigned RTC_MODE_SYNC = 0;
    localparam int unsigned RTC_MODE_DIV  = 1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP_LO,
        REG_MTIMECMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI,
        REG_SETSSIP
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [5:0] hart;
    } reg_dec_t;

    // Decode one 32-bit word address; offsets below a region base wrap to large values and miss.
    function automatic reg_dec_t decode(input logic [31:0] a, input int unsigned n_cores);
        reg_dec_t    d;
        logic [31:0] off_msip;
        logic [31:0] off_cmp;
        logic [31:0] off_ssip;
        d        = '{sel: REG_NONE, hart: 6'd0};
        off_msip = a - 32'(MSIP_BASE);
        off_cmp  = a - 32'(MTIMECMP_BASE);
        off_ssip = a - 32'(SETSSIP_BASE);
        if (off_msip < 32'(4 * n_cores)) begin
            d.sel  = REG_MSIP;
            d.hart = 6'(off_msip >> 2);
        end else if (off_cmp < 32'(8 * n_cores)) begin
            d.sel  = off_cmp[2] ? REG_MTIMECMP_HI : REG_MTIMECMP_LO;
            d.hart = 6'(off_cmp >> 3);
        end else if (a == 32'(MTIME_BASE)) begin
            d.sel = REG_MTIME_LO;
        end else if (a == 32'(MTIME_BASE) + 32'd4) begin
            d.sel = REG_MTIME_HI;
        end else if (off_ssip < 32'(4 * n_cores)) begin
            d.sel  = REG_SETSSIP;
            d.hart = 6'(off_ssip >> 2);
        end
        return d;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int unsigned b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aclint_rtc_tick.sv
// Produces a single-cycle mtime tick from either a synchronised rt_clk rising edge or a clk divider.
module aclint_rtc_tick
    import aclint_pkg::*;
#(
    parameter int unsigned RTC_MODE = RTC_MODE_SYNC,
    parameter int unsigned RTC_DIV  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic rt_clk,
    output logic tick_c
);

    localparam int unsigned CNT_W = (RTC_DIV > 2) ? $clog2(RTC_DIV) : 1;

    logic [2:0]       sync_q;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic [CNT_W-1:0] cnt_q;
    logic             edge_tick;
    logic             div_tick;

    // sync_q[1] is the synchronised level, sync_q[2] its previous value for edge detection.
    // armed_q requires a real low sample after reset, so a high rt_clk at release is not an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q  <= 3'b000;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[1:0], rt_clk};
            fill_q  <= (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
            armed_q <= armed_q | ((fill_q == 2'd2) & ~sync_q[1]);
            cnt_q   <= (cnt_q == CNT_W'(RTC_DIV - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign edge_tick = armed_q & sync_q[1] & ~sync_q[2];
    assign div_tick  = (cnt_q == CNT_W'(RTC_DIV - 1));
    assign tick_c    = (RTC_MODE == RTC_MODE_DIV) ? div_tick : edge_tick;

endmodule

// File: rtl/aclint_mt.sv
// ACLINT machine timer / software interrupt block: MSIP, MTIMECMP, MTIME and SETSSIP registers
// behind a single-cycle valid/ready register port.
module aclint_mt
    import aclint_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_CORES  = 1,
    parameter int unsigned RTC_MODE = RTC_MODE_SYNC,
    parameter int unsigned RTC_DIV  = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rt_clk,
    input  logic                  valid,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic [N_CORES-1:0]    mtip,
    output logic [N_CORES-1:0]    msip,
    output logic [N_CORES-1:0]    ssip
);

    localparam int unsigned NW     = DATA_W / 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned HART_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic               tick_c;
    logic [31:0]        base_addr;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q [N_CORES];
    logic [63:0]        cmp_d [N_CORES];
    logic [31:0]        shadow_q, shadow_d;
    logic [N_CORES-1:0] msip_q, msip_d;
    logic [N_CORES-1:0] ssip_q, ssip_d;
    logic [N_CORES-1:0] mtip_q, mtip_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ready_q;

    aclint_rtc_tick #(
        .RTC_MODE (RTC_MODE),
        .RTC_DIV  (RTC_DIV)
    ) u_rtc_tick (
        .clk    (clk),
        .reset  (reset),
        .rt_clk (rt_clk),
        .tick_c (tick_c)
    );

    // Each 32-bit lane of the bus is decoded as its own word address.
    assign base_addr = 32'(address) & ~32'(STRB_W - 1);

    always_comb begin
        reg_dec_t          dec;
        logic [HART_W-1:0] h;
        logic [3:0]        strb;
        logic [31:0]       wd;
        logic [31:0]       word;
        logic              is_read;
        logic              mtime_wr;

        mtime_d  = mtime_q;
        cmp_d    = cmp_q;
        shadow_d = shadow_q;
        msip_d   = msip_q;
        ssip_d   = '0;
        rdata_d  = '0;
        dec      = '{sel: REG_NONE, hart: 6'd0};
        h        = '0;
        strb     = 4'b0;
        wd       = 32'b0;
        word     = 32'b0;
        mtime_wr = 1'b0;
        is_read  = valid && (wstrb == '0);

        for (int unsigned k = 0; k < NW; k++) begin
            dec  = decode(base_addr + 32'(4 * k), N_CORES);
            h    = HART_W'(dec.hart);
            strb = valid ? wstrb[4*k +: 4] : 4'b0;
            wd   = wdata[32*k +: 32];
            word = 32'b0;
            case (dec.sel)
                REG_MSIP: begin
                    word = 32'(msip_q[h]);
                    if (strb[0]) msip_d[h] = wd[0];
                end
                REG_MTIMECMP_LO: begin
                    word = cmp_q[h][31:0];
                    cmp_d[h][31:0] = merge_bytes(cmp_q[h][31:0], wd, strb);
                end
                REG_MTIMECMP_HI: begin
                    word = cmp_q[h][63:32];
                    cmp_d[h][63:32] = merge_bytes(cmp_q[h][63:32], wd, strb);
                end
                REG_MTIME_LO: begin
                    word          = mtime_q[31:0];
                    mtime_d[31:0] = merge_bytes(mtime_q[31:0], wd, strb);
                    mtime_wr      = mtime_wr | (|strb);
                    if (is_read && (NW == 1)) shadow_d = mtime_q[63:32];
                end
                REG_MTIME_HI: begin
                    word           = (NW == 1) ? shadow_q : mtime_q[63:32];
                    mtime_d[63:32] = merge_bytes(mtime_q[63:32], wd, strb);
                    mtime_wr       = mtime_wr | (|strb);
                end
                REG_SETSSIP: begin
                    if (strb[0] && wd[0]) ssip_d[h] = 1'b1;
                end
                default: ;
            endcase
            if (is_read) rdata_d[32*k +: 32] = word;
        end

        // A software write to mtime wins over a coincident tick.
        if (!mtime_wr && tick_c) mtime_d = mtime_q + 64'd1;

        for (int unsigned i = 0; i < N_CORES; i++) begin
            mtip_d[i] = (mtime_q >= cmp_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime_q  <= MTIME_RST;
            for (int unsigned i = 0; i < N_CORES; i++) cmp_q[i] <= MTIMECMP_RST;
            shadow_q <= 32'b0;
            msip_q   <= '0;
            ssip_q   <= '0;
            mtip_q   <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            msip_q   <= msip_d;
            ssip_q   <= ssip_d;
            mtip_q   <= mtip_d;
            rdata_q  <= rdata_d;
            ready_q  <= valid;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign mtip  = mtip_q;
    assign msip  = msip_q;
    assign ssip  = ssip_q;

endmodule
